// File: rtl/bsg_blackparrot_mc_throttle_pkg.sv
// Shared definitions for the BlackParrot proc-link credit throttle.
//   - bp_mc_throttle_state_e : drain FSM states
//   - max_out_credits_default_gp : default cap on in-flight BP fwd requests
//   - packet/link width helpers, so the top and any instantiating code agree
//     on the flattened link_sif layout:
//       link_sif = {fwd channel, rev channel}
//       channel  = {v, data, ready_and_rev}
package bsg_blackparrot_mc_throttle_pkg;

   typedef enum logic [1:0] {
      eRun     = 2'd0,
      eDrain   = 2'd1,
      eDrained = 2'd2
   } bp_mc_throttle_state_e;

   localparam int max_out_credits_default_gp = 16;

   localparam int op_width_gp       = 2;
   localparam int reg_id_width_gp   = 5;
   localparam int rev_type_width_gp = 2;

   // fwd packet: addr, op, op_ex (byte mask), reg_id, payload, src y/x, dst y/x
   function automatic int fwd_packet_width(int addr_w, int data_w, int x_w, int y_w);
      return addr_w + op_width_gp + (data_w / 8) + reg_id_width_gp + data_w
             + 2 * (x_w + y_w);
   endfunction

   // rev packet: type, data, reg_id, dst y/x
   function automatic int rev_packet_width(int data_w, int x_w, int y_w);
      return rev_type_width_gp + data_w + reg_id_width_gp + x_w + y_w;
   endfunction

   // two channels, each carrying v and ready_and_rev next to its packet
   function automatic int link_sif_width(int addr_w, int data_w, int x_w, int y_w);
      return fwd_packet_width(addr_w, data_w, x_w, y_w)
             + rev_packet_width(data_w, x_w, y_w) + 4;
   endfunction

endpackage

// File: rtl/bsg_blackparrot_mc_two_fifo.sv
// Two-entry valid/ready FIFO.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   v_i, data_i    : enqueue side; ready_and_o is high whenever not full
//   v_o, data_o    : head of queue; data_o is stable while v_o is high
//   yumi_i         : consumer takes the head this cycle (only meaningful with v_o)
// Sustains one transfer per cycle as long as the consumer keeps draining.
module bsg_blackparrot_mc_two_fifo #(
   parameter int width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_and_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   logic [width_p-1:0] mem_r [2];
   logic               wr_ptr_r;
   logic               rd_ptr_r;
   logic [1:0]         count_r;
   logic               enq;
   logic               deq;

   assign ready_and_o = (count_r != 2'd2);
   assign v_o         = (count_r != 2'd0);
   assign data_o      = mem_r[rd_ptr_r];

   assign enq = v_i & ready_and_o;
   assign deq = yumi_i & v_o;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (enq) wr_ptr_r <= ~wr_ptr_r;
         if (deq) rd_ptr_r <= ~rd_ptr_r;
         unique case ({enq, deq})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // NOTE: storage is not reset; the occupancy count alone decides what is
   // valid, so clearing the data would only add reset fan-out.
   always_ff @(posedge clk_i) begin
      if (enq) mem_r[wr_ptr_r] <= data_i;
   end

endmodule

// File: rtl/bsg_blackparrot_mc_link_throttle.sv
// Credit-limiting stage on one BlackParrot proc link (manycore clock domain).
// Sits between the CDC's manycore side and the router's proc port.
//   clk_i, reset_i     : manycore clock, asynchronous active-high reset
//   proc_link_sif_i/o  : CDC side; fwd in = BP requests, rev in = BP responses
//   router_link_sif_i/o: router proc port side
//   drain_i            : level request to stop issuing new BP requests
//   drained_o          : no BP request buffered or outstanding, drain held
//   credits_used_o     : BP requests dispatched and not yet answered
//   underflow_o        : sticky; a response returned with nothing outstanding
// BP fwd requests are buffered and released only while credits remain; the
// other three channels are wired straight through.
module bsg_blackparrot_mc_link_throttle
   import bsg_blackparrot_mc_throttle_pkg::*;
#(
   // width defaults are placeholders; every instance sets them
   parameter int addr_width_p      = 28,
   parameter int data_width_p      = 32,
   parameter int x_cord_width_p    = 7,
   parameter int y_cord_width_p    = 7,
   parameter int max_out_credits_p = max_out_credits_default_gp,
   localparam int credit_width_lp  = $clog2(max_out_credits_p + 1),
   localparam int link_sif_width_lp =
      link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [link_sif_width_lp-1:0] proc_link_sif_i,
   output logic [link_sif_width_lp-1:0] proc_link_sif_o,
   input  logic [link_sif_width_lp-1:0] router_link_sif_i,
   output logic [link_sif_width_lp-1:0] router_link_sif_o,
   input  logic                         drain_i,
   output logic                         drained_o,
   output logic [credit_width_lp-1:0]   credits_used_o,
   output logic                         underflow_o
);

   localparam int fwd_width_lp =
      fwd_packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);
   localparam int rev_width_lp =
      rev_packet_width(data_width_p, x_cord_width_p, y_cord_width_p);
   localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

   typedef struct packed {
      logic                    v;
      logic [fwd_width_lp-1:0] data;
      logic                    ready_and_rev;
   } fwd_ch_s;

   typedef struct packed {
      logic                    v;
      logic [rev_width_lp-1:0] data;
      logic                    ready_and_rev;
   } rev_ch_s;

   typedef struct packed {
      fwd_ch_s fwd;
      rev_ch_s rev;
   } link_sif_s;

   link_sif_s proc_in, router_in, proc_out, router_out;

   assign proc_in           = proc_link_sif_i;
   assign router_in         = router_link_sif_i;
   assign proc_link_sif_o   = proc_out;
   assign router_link_sif_o = router_out;

   bp_mc_throttle_state_e       state_r, state_n;
   logic [credit_width_lp-1:0] credits_r;
   logic                       underflow_r;

   logic                    accept_en;
   logic                    fifo_ready;
   logic                    fifo_v;
   logic [fwd_width_lp-1:0] fifo_data;
   logic                    issue_v;
   logic                    dispatch;
   logic                    credit_return;

   // new requests are taken only in RUN; DRAIN still flushes what is buffered
   assign accept_en = (state_r == eRun);

   // limit is checked on the registered count, so issue_v never looks at ready
   assign issue_v       = fifo_v && (state_r != eDrained) && (credits_r < max_credits_lp);
   assign dispatch      = issue_v && router_in.fwd.ready_and_rev;
   assign credit_return = router_in.rev.v && proc_in.rev.ready_and_rev;

   bsg_blackparrot_mc_two_fifo #(
      .width_p (fwd_width_lp)
   ) fwd_fifo (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .v_i         (proc_in.fwd.v & accept_en),
      .data_i      (proc_in.fwd.data),
      .ready_and_o (fifo_ready),
      .v_o         (fifo_v),
      .data_o      (fifo_data),
      .yumi_i      (dispatch)
   );

   always_comb begin
      proc_out   = '0;
      router_out = '0;

      // throttled BP request path
      proc_out.fwd.ready_and_rev = fifo_ready & accept_en;
      router_out.fwd.v           = issue_v;
      router_out.fwd.data        = fifo_data;

      // manycore requests to BP
      proc_out.fwd.v               = router_in.fwd.v;
      proc_out.fwd.data            = router_in.fwd.data;
      router_out.fwd.ready_and_rev = proc_in.fwd.ready_and_rev;

      // responses to BP requests (these return credits)
      proc_out.rev.v               = router_in.rev.v;
      proc_out.rev.data            = router_in.rev.data;
      router_out.rev.ready_and_rev = proc_in.rev.ready_and_rev;

      // BP responses to manycore requests
      router_out.rev.v           = proc_in.rev.v;
      router_out.rev.data        = proc_in.rev.data;
      proc_out.rev.ready_and_rev = router_in.rev.ready_and_rev;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         credits_r   <= '0;
         underflow_r <= 1'b0;
      end else begin
         unique case ({dispatch, credit_return})
            2'b10: credits_r <= credits_r + credit_width_lp'(1);
            2'b01: begin
               // a response with nothing outstanding (e.g. after a warm reset)
               if (credits_r == '0) underflow_r <= 1'b1;
               else                 credits_r   <= credits_r - credit_width_lp'(1);
            end
            default: credits_r <= credits_r;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_r <= eRun;
      else         state_r <= state_n;
   end

   // NOTE: state_n is given its hold value before the case so every path
   // assigns it and no latch is inferred.
   always_comb begin
      state_n = state_r;
      unique case (state_r)
         eRun:     if (drain_i) state_n = eDrain;
         eDrain: begin
            // withdrawing the request wins over a same-cycle completion
            if (!drain_i)                          state_n = eRun;
            else if (!fifo_v && credits_r == '0)   state_n = eDrained;
         end
         eDrained: if (!drain_i) state_n = eRun;
         default:  state_n = eRun;
      endcase
   end

   assign drained_o      = (state_r == eDrained);
   assign credits_used_o = credits_r;
   assign underflow_o    = underflow_r;

endmodule
